// File: rtl/alu_uart_interface.sv
// Frame sequencer between a UART and a combinational ALU: collects A, B, op
// bytes, presents them to the ALU, then hands the result to the transmitter.
module alu_uart_interface #(
   parameter int NB_DATA     = 8,
   parameter int NB_OP       = 6,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_busy,
   input  logic               i_tx_done,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_operation_code,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic               o_timeout,
   output logic               o_overrun
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam bit WDOG_EN = (TIMEOUT_CYC > 0);

   typedef enum logic [2:0] {
      WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NB_DATA-1:0] data_a_q, data_a_d;
   logic [NB_DATA-1:0] data_b_q, data_b_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic               timeout_q, timeout_d;
   logic               overrun_q, overrun_d;

   // Upper op-byte bits are intentionally discarded.
   generate
      if (NB_OP < NB_DATA) begin : g_op_trunc
         logic unused_op_hi;
         assign unused_op_hi = ^i_rx_data[NB_DATA-1:NB_OP];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      timeout_d  = 1'b0;
      overrun_d  = overrun_q;
      unique case (state_q)
         WAIT_A: begin
            cnt_d = '0;
            if (i_rx_done) begin
               data_a_d = i_rx_data;
               state_d  = WAIT_B;
            end
         end
         WAIT_B, WAIT_OP: begin
            // An arriving byte takes priority over an expiring watchdog.
            if (i_rx_done) begin
               cnt_d = '0;
               if (state_q == WAIT_B) begin
                  data_b_d = i_rx_data;
                  state_d  = WAIT_OP;
               end else begin
                  op_d    = i_rx_data[NB_OP-1:0];
                  state_d = EXEC;
               end
            end else if (WDOG_EN && cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = WAIT_A;
            end else if (WDOG_EN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         EXEC: begin
            tx_data_d = i_alu_result;
            state_d   = SEND;
         end
         SEND: begin
            if (!i_tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (i_tx_done) state_d = WAIT_A;
         end
         default: state_d = WAIT_A;
      endcase
      if (i_rx_done && (state_q == EXEC || state_q == SEND || state_q == WAIT_TX))
         overrun_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= WAIT_A;
         cnt_q      <= '0;
         data_a_q   <= '0;
         data_b_q   <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         timeout_q  <= timeout_d;
         overrun_q  <= overrun_d;
      end
   end

   assign o_tx_start       = tx_start_q;
   assign o_tx_data        = tx_data_q;
   assign o_data_a         = data_a_q;
   assign o_data_b         = data_b_q;
   assign o_operation_code = op_q;
   assign o_timeout        = timeout_q;
   assign o_overrun        = overrun_q;

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Frame sequencer between the UART receiver/transmitter and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, operation code) and drives them as registered ALU inputs.
- Captures the ALU result one cycle later and hands it to the UART transmitter with a start/done handshake.
- A watchdog discards partially received frames.

Parameters:
- NB_DATA, 8, width of UART bytes, ALU operands and result
- NB_OP, 6, width of the ALU operation code; taken from the low NB_OP bits of the op byte (NB_OP <= NB_DATA)
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes of one frame; 0 disables the watchdog

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, byte available
- i_tx_busy  in  1  transmitter is sending
- i_tx_done  in  1  one-cycle pulse, transmission finished
- o_tx_start  out  1  one-cycle request to transmit o_tx_data
- o_tx_data  out  NB_DATA  byte to transmit (ALU result)
- o_data_a  out  NB_DATA  ALU operand A
- o_data_b  out  NB_DATA  ALU operand B
- o_operation_code  out  NB_OP  ALU operation code
- i_alu_result  in  NB_DATA  combinational ALU result
- o_timeout  out  1  one-cycle pulse, partial frame discarded
- o_overrun  out  1  sticky, a byte arrived while not accepting

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: all outputs 0; state = WAIT_A; watchdog counter = 0.
- All outputs are registered.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_data_a <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_data_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_operation_code <= i_rx_data[NB_OP-1:0] (upper bits ignored), go to EXEC.
- EXEC: lasts exactly one cycle so the ALU settles on the registered inputs. At its closing edge, o_tx_data <= i_alu_result and go to SEND.
- SEND: on the first edge with i_tx_busy=0, o_tx_start <= 1 for exactly one cycle and go to WAIT_TX. Otherwise stay in SEND with o_tx_start=0.
- WAIT_TX: on i_tx_done, go to WAIT_A. An i_tx_done pulse in any other state is ignored.
- Latency: op byte sampled at edge N -> EXEC during cycle N..N+1 -> result captured at N+1 -> o_tx_start high from N+2 to N+3 when the transmitter is idle.
- Operand and op outputs hold their values between frames; they change only when the corresponding byte is accepted.
- Overrun: i_rx_done in EXEC, SEND or WAIT_TX drops the byte and sets o_overrun=1. o_overrun clears only on reset. The FSM and registers are unaffected.
- Watchdog (TIMEOUT_CYC > 0):
  - Counter is active only in WAIT_B and WAIT_OP.
  - It clears on entry to those states and on every accepted byte.
  - It increments each cycle without i_rx_done.
  - When it reaches TIMEOUT_CYC-1 with no byte that cycle: o_timeout pulses for one cycle, state goes to WAIT_A, counter clears. Operand registers keep their old values.
- Simultaneous byte and watchdog expiry: the byte wins. It is accepted, no timeout occurs, and the counter clears.
- TIMEOUT_CYC=0: the counter is held at 0 and o_timeout is never asserted.
- Reset asserted mid-frame or mid-transmit: immediate return to reset values. A pending o_tx_start is cancelled.
- Widths: no arithmetic besides the counter. Counter width is $clog2(TIMEOUT_CYC+1), minimum 1.

Test Plan:
- ADD frame: rx bytes 0x05, 0x03, 0x20 with i_tx_busy=0 and ALU model attached -> o_data_a=0x05, o_data_b=0x03, o_operation_code=0x20; o_tx_data=0x08; single o_tx_start pulse 2 cycles after the op byte; i_tx_done -> back in WAIT_A.
- SUB with op upper bits set: bytes 0x03, 0x05, 0xE2 -> o_operation_code=0x22, o_tx_data=0xFE; then an unknown op 0x3F -> o_tx_data=0x00.
- Transmitter busy: hold i_tx_busy=1 for 10 cycles after frame 0x02, 0x02, 0x20 -> o_tx_start stays 0 and is asserted exactly once, the cycle after i_tx_busy falls; o_tx_data=0x04 throughout.
- Watchdog with TIMEOUT_CYC=16: send 0x01 only and wait 16 cycles -> one o_timeout pulse, state WAIT_A; then 0x01, 0x02, 0x22 -> o_tx_data=0xFF. Also place a byte on the expiry cycle -> no timeout and the byte is accepted as B.
- Overrun: during WAIT_TX pulse i_rx_done with 0xAA -> o_overrun=1; o_data_a unchanged; the next frame processes normally and o_overrun stays 1 until reset.
- Reset mid-frame: after bytes 0x05, 0x03, pull i_rst_n low asynchronously between edges -> all outputs 0 immediately; after release, a full frame 0x07, 0x01, 0x22 -> o_tx_data=0x06.
